// File: rtl/rtc_axi_responder_if.sv
// rtc_axi_responder_if: AXI4-Lite read/write channels between
// the crossbar (master) and the RTC responder (slave).
interface rtc_axi_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/rtc_axi_responder.sv
// rtc_axi_responder: AXI4-Lite slave holding a free-running 64-bit mtime.
// Reads return the counter as two coherent words; writes get SLVERR.
module rtc_axi_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'ha000_0048,
    parameter int          TICK_DIV   = 1,
    parameter int          RD_LATENCY = 0
) (
    input  logic               clk,
    input  logic               rst,
    rtc_axi_responder_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] WAIT_LAST =
        (RD_LATENCY > 1) ? 4'(RD_LATENCY - 1) : 4'd0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    logic [PW-1:0] presc;
    logic [63:0]   mtime;
    logic [63:0]   snap;

    r_state_t      r_state;
    r_state_t      r_next;
    logic [3:0]    wait_cnt;
    logic [31:0]   off;
    logic [31:0]   rd_word;
    logic [1:0]    rd_resp;
    logic          snap_load;
    logic          ar_hs;
    logic          r_hs;
    logic          rd_err;
    logic          rd_lo;
    logic          rd_hi;

    w_state_t      w_state;
    w_state_t      w_next;
    logic          aw_taken;
    logic          w_taken;
    logic          aw_taken_d;
    logic          w_taken_d;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;
    logic          b_pend;

    logic          unused_bits;

    // Write payload and byte lane bits are intentionally discarded.
    assign unused_bits = ^{bus.awaddr, bus.wdata, bus.wstrb, off[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign off   = bus.araddr - ADDR_BASE;
    assign ar_hs = bus.arvalid && bus.arready;
    assign r_hs  = bus.rvalid && bus.rready;

    assign rd_err = (off[31:3] != 29'd0);
    assign rd_lo  = !rd_err && !off[2];
    assign rd_hi  = !rd_err && off[2];

    always_comb begin
        rd_word   = 32'd0;
        rd_resp   = RESP_DECERR;
        snap_load = 1'b0;
        unique case (1'b1)
            rd_lo: begin
                rd_word   = mtime[31:0];
                rd_resp   = RESP_OKAY;
                snap_load = 1'b1;
            end
            rd_hi: begin
                rd_word = snap[63:32];
                rd_resp = RESP_OKAY;
            end
            default: begin
                rd_word = 32'd0;
                rd_resp = RESP_DECERR;
            end
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_next = (RD_LATENCY == 0) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                if (r_hs) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // rvalid lags entry into R_RESP by one edge, so a zero-latency
    // read still answers on the edge after the AR handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            wait_cnt    <= '0;
            snap        <= '0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= '0;
        end else begin
            r_state     <= r_next;
            bus.arready <= (r_next == R_IDLE);
            bus.rvalid  <= (r_state == R_RESP) && !r_hs;
            if (r_state == R_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (ar_hs) begin
                bus.rdata <= rd_word;
                bus.rresp <= rd_resp;
                if (snap_load) begin
                    snap <= mtime;
                end
            end
        end
    end

    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign b_hs   = bus.bvalid && bus.bready;
    assign b_pend = (w_state == W_RESP) && !b_hs;

    always_comb begin
        w_next     = w_state;
        aw_taken_d = aw_taken;
        w_taken_d  = w_taken;
        unique case (w_state)
            W_IDLE: begin
                aw_taken_d = aw_taken || aw_hs;
                w_taken_d  = w_taken || w_hs;
                if (aw_taken_d && w_taken_d) begin
                    w_next     = W_RESP;
                    aw_taken_d = 1'b0;
                    w_taken_d  = 1'b0;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state     <= W_IDLE;
            aw_taken    <= 1'b0;
            w_taken     <= 1'b0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= '0;
        end else begin
            w_state     <= w_next;
            aw_taken    <= aw_taken_d;
            w_taken     <= w_taken_d;
            bus.awready <= (w_next == W_IDLE) && !aw_taken_d;
            bus.wready  <= (w_next == W_IDLE) && !w_taken_d;
            bus.bvalid  <= b_pend;
            bus.bresp   <= b_pend ? RESP_SLVERR : RESP_OKAY;
        end
    end
endmodule

// File: tb/tb_rtc_axi_responder.sv
// tb_rtc_axi_responder: table-driven reads plus hand-written corner
// sequences, with a response scoreboard for R and B channels.
module tb_rtc_axi_responder;
    localparam logic [31:0] BASE = 32'ha000_0048;

    typedef enum int {S_LOW, S_HIGH, S_ZERO} src_t;

    typedef struct {
        logic [31:0] addr;
        int          rdly;
        logic [1:0]  resp;
        src_t        src;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    longint unsigned ncyc = 0;
    logic [63:0] mt_adj = 64'd0;
    logic [63:0] snap_m = 64'd0;
    logic [31:0] got;
    logic [31:0] got_c;

    rsp_t       exp_q[$];
    logic [1:0] b_q[$];
    vec_t       tbl[12];

    rtc_axi_responder_if bus0 ();
    rtc_axi_responder_if bus3 ();

    rtc_axi_responder #(
        .ADDR_BASE (BASE),
        .TICK_DIV  (1),
        .RD_LATENCY(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    rtc_axi_responder #(
        .ADDR_BASE (BASE),
        .TICK_DIV  (3),
        .RD_LATENCY(3)
    ) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release: the expected mtime at TICK_DIV=1.
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic rd0(input logic [31:0] addr, input int rdly,
                       input logic [1:0] xresp, input src_t src,
                       input string nm, output logic [31:0] val);
        rsp_t e;
        logic [63:0] mt;
        int n;
        bus0.araddr  = addr;
        bus0.arvalid = 1'b1;
        bus0.rready  = 1'b0;
        n = 0;
        while (bus0.arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " ar_wait"}, 64'(n < 20), 64'd1);
        mt = ncyc + mt_adj;
        e.resp = xresp;
        case (src)
            S_LOW: begin
                e.data = mt[31:0];
                snap_m = mt;
            end
            S_HIGH:  e.data = snap_m[63:32];
            default: e.data = 32'd0;
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        bus0.arvalid = 1'b0;
        check({nm, " busy"}, 64'({bus0.arready, bus0.rvalid}), 64'd0);
        @(negedge clk);
        check({nm, " rvalid"}, 64'(bus0.rvalid), 64'd1);
        repeat (rdly) begin
            @(negedge clk);
            check({nm, " hold"}, 64'({bus0.rvalid, bus0.arready, bus0.rdata}),
                  64'({2'b10, exp_q[0].data}));
        end
        bus0.rready = 1'b1;
        if (exp_q.size() == 0) begin
            check({nm, " sb_empty"}, 64'd0, 64'd1);
            e.data = 32'd0;
        end else begin
            e = exp_q.pop_front();
        end
        check({nm, " rdata"}, 64'(bus0.rdata), 64'(e.data));
        check({nm, " rresp"}, 64'(bus0.rresp), 64'(e.resp));
        val = bus0.rdata;
        @(negedge clk);
        bus0.rready = 1'b0;
        check({nm, " r_done"}, 64'({bus0.rvalid, bus0.arready}), 64'd1);
    endtask

    task automatic wr0(input int da, input int dw, input string nm);
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        int c;
        int n;
        logic [1:0] xb;
        aw_done = 1'b0;
        w_done  = 1'b0;
        c = 0;
        b_q.push_back(2'b10);
        bus0.awaddr = BASE;
        bus0.wdata  = 32'hdead_beef;
        bus0.wstrb  = 4'hf;
        bus0.bready = 1'b0;
        while (!(aw_done && w_done) && c < 20) begin
            bus0.awvalid = (c >= da) && !aw_done;
            bus0.wvalid  = (c >= dw) && !w_done;
            if (aw_done) check({nm, " aw_off"}, 64'(bus0.awready), 64'd0);
            if (w_done)  check({nm, " w_off"}, 64'(bus0.wready), 64'd0);
            hs_aw = bus0.awvalid && bus0.awready;
            hs_w  = bus0.wvalid && bus0.wready;
            @(negedge clk);
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            c++;
        end
        bus0.awvalid = 1'b0;
        bus0.wvalid  = 1'b0;
        check({nm, " taken"}, 64'(aw_done && w_done), 64'd1);
        check({nm, " b_early"},
              64'({bus0.bvalid, bus0.awready, bus0.wready}), 64'd0);
        @(negedge clk);
        xb = (b_q.size() != 0) ? b_q.pop_front() : 2'b00;
        check({nm, " bvalid"}, 64'(bus0.bvalid), 64'd1);
        check({nm, " bresp"}, 64'(bus0.bresp), 64'(xb));
        @(negedge clk);
        check({nm, " b_hold"}, 64'({bus0.bvalid, bus0.bresp}),
              64'({1'b1, xb}));
        bus0.bready = 1'b1;
        @(negedge clk);
        bus0.bready = 1'b0;
        check({nm, " b_done"},
              64'({bus0.bvalid, bus0.awready, bus0.wready}), 64'd3);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus0.bvalid) n++;
        end
        check({nm, " single_b"}, 64'(n), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t e;
        int n;

        tbl[0]  = '{BASE,           0, 2'b00, S_LOW};
        tbl[1]  = '{BASE + 32'd8,   0, 2'b11, S_ZERO};
        tbl[2]  = '{BASE + 32'd4,   1, 2'b00, S_HIGH};
        tbl[3]  = '{BASE + 32'd2,   2, 2'b00, S_LOW};
        tbl[4]  = '{BASE + 32'd7,   0, 2'b00, S_HIGH};
        tbl[5]  = '{BASE - 32'd4,   0, 2'b11, S_ZERO};
        tbl[6]  = '{BASE + 32'd12,  0, 2'b11, S_ZERO};
        tbl[7]  = '{32'd0,          0, 2'b11, S_ZERO};
        tbl[8]  = '{BASE + 32'd8,   1, 2'b11, S_ZERO};
        tbl[9]  = '{BASE,           3, 2'b00, S_LOW};
        tbl[10] = '{BASE + 32'd6,   0, 2'b00, S_HIGH};
        tbl[11] = '{BASE + 32'd1,   0, 2'b00, S_LOW};

        bus0.araddr = '0; bus0.arvalid = 1'b0; bus0.rready = 1'b0;
        bus0.awaddr = '0; bus0.awvalid = 1'b0; bus0.wdata = '0;
        bus0.wstrb = '0;  bus0.wvalid = 1'b0;  bus0.bready = 1'b0;
        bus3.araddr = '0; bus3.arvalid = 1'b0; bus3.rready = 1'b0;
        bus3.awaddr = '0; bus3.awvalid = 1'b0; bus3.wdata = '0;
        bus3.wstrb = '0;  bus3.wvalid = 1'b0;  bus3.bready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset outs", 64'({bus0.arready, bus0.rvalid, bus0.awready,
              bus0.wready, bus0.bvalid, bus0.rresp, bus0.bresp}), 64'd0);
        check("reset rdata", 64'(bus0.rdata), 64'd0);
        check("reset outs3", 64'({bus3.arready, bus3.rvalid,
              bus3.awready, bus3.wready, bus3.bvalid}), 64'd0);

        rst = 1'b0;
        repeat (9) @(negedge clk);
        rd0(BASE, 0, 2'b00, S_LOW, "cycle10", got);
        check("cycle10 value", 64'(got), 64'd9);

        dut.mtime = 64'h0000_0001_FFFF_FFFF;
        mt_adj = 64'h0000_0001_FFFF_FFFF - ncyc;
        rd0(BASE, 0, 2'b00, S_LOW, "wrap_lo", got);
        check("wrap_lo value", 64'(got), 64'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        rd0(BASE + 32'd4, 0, 2'b00, S_HIGH, "wrap_hi", got);
        check("wrap_hi value", 64'(got), 64'd1);

        for (int i = 0; i < 12; i++) begin
            rd0(tbl[i].addr, tbl[i].rdly, tbl[i].resp, tbl[i].src,
                $sformatf("vec%0d", i), got);
        end

        wr0(2, 0, "w_first");
        wr0(0, 2, "aw_first");
        wr0(0, 0, "aw_w_same");
        rd0(BASE, 0, 2'b00, S_LOW, "after_wr", got);

        fork
            rd0(BASE, 1, 2'b00, S_LOW, "conc_rd", got_c);
            wr0(1, 0, "conc_wr");
        join

        // Latency-3 instance with a divide-by-3 prescaler.
        bus3.araddr  = BASE;
        bus3.arvalid = 1'b1;
        bus3.rready  = 1'b0;
        n = 0;
        while (bus3.arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lat3 ar_wait", 64'(n < 20), 64'd1);
        e.data = 32'(ncyc / 3);
        e.resp = 2'b00;
        exp_q.push_back(e);
        @(negedge clk);
        bus3.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lat3 wait%0d", i),
                  64'({bus3.rvalid, bus3.arready}), 64'd0);
            @(negedge clk);
        end
        check("lat3 rvalid", 64'(bus3.rvalid), 64'd1);
        repeat (4) begin
            @(negedge clk);
            check("lat3 hold", 64'({bus3.rvalid, bus3.arready, bus3.rdata}),
                  64'({2'b10, exp_q[0].data}));
        end
        bus3.rready = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '{32'd0, 2'b01};
        check("lat3 rdata", 64'(bus3.rdata), 64'(e.data));
        check("lat3 rresp", 64'(bus3.rresp), 64'(e.resp));
        @(negedge clk);
        bus3.rready = 1'b0;
        check("lat3 done", 64'({bus3.rvalid, bus3.arready}), 64'd1);

        bus0.araddr  = BASE;
        bus0.arvalid = 1'b1;
        bus0.rready  = 1'b0;
        n = 0;
        while (bus0.arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid ar_wait", 64'(n < 20), 64'd1);
        exp_q.push_back('{32'd0, 2'b00});
        @(negedge clk);
        bus0.arvalid = 1'b0;
        @(negedge clk);
        check("rst_mid pre", 64'(bus0.rvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid async", 64'({bus0.rvalid, bus0.arready}), 64'd0);
        check("rst_mid mtime", dut.mtime, 64'd0);
        exp_q.delete();
        b_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mt_adj = 64'd0;
        snap_m = 64'd0;
        rd0(BASE + 32'd4, 0, 2'b00, S_HIGH, "post_rst_hi", got);
        check("post_rst_hi zero", 64'(got), 64'd0);
        rd0(BASE, 0, 2'b00, S_LOW, "post_rst_lo", got);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
